// File: rtl/i2c_codec_responder.sv
// i2c_codec_responder: WM8731-style I2C write target that ACKs 3-byte writes and stores 9-bit words in a register file.
// Optional CODEC_SOFT_RESET_EN: a write to reg 0x0F clears the whole register file.
module i2c_codec_responder #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic       o_wr_valid,
    output logic [6:0] o_wr_addr,
    output logic [8:0] o_wr_data,
    output logic       o_busy,
    input  logic [3:0] i_rd_addr,
    output logic [8:0] o_rd_data
);
    localparam int AW = $clog2(NUM_REGS);
    typedef enum logic [2:0] {IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_s, sda_s, scl_d, sda_d;
    logic scl_rise, scl_fall, start, stop;
    logic [2:0] cnt;
    logic full;
    logic [7:0] sh, b1;
    logic [6:0] waddr;
    logic [8:0] wdata;
    logic in_range;
    logic [8:0] regs [NUM_REGS];
    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start    = scl_s & scl_d & sda_d & ~sda_s;
    assign stop     = scl_s & scl_d & ~sda_d & sda_s;
    assign waddr    = b1[7:1];
    assign wdata    = {b1[0], sh};
    assign in_range = 32'(waddr) < NUM_REGS;
    assign o_rd_data = regs[i_rd_addr[AW-1:0]];
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scl_sync   <= '1;
            sda_sync   <= '1;
            scl_d      <= 1'b1;
            sda_d      <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            full       <= 1'b0;
            sh         <= '0;
            b1         <= '0;
            o_sda_oe   <= 1'b0;
            o_wr_valid <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
            o_busy     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            scl_sync   <= {scl_sync[SYNC_STAGES-2:0], i_scl};
            sda_sync   <= {sda_sync[SYNC_STAGES-2:0], i_sda};
            scl_d      <= scl_s;
            sda_d      <= sda_s;
            o_wr_valid <= 1'b0;
            if (stop) begin
                state    <= IDLE;
                o_busy   <= 1'b0;
                o_sda_oe <= 1'b0;
            end else if (start) begin
                state    <= ADDR;
                cnt      <= '0;
                full     <= 1'b0;
                o_busy   <= 1'b1;
                o_sda_oe <= 1'b0;
            end else if (scl_rise && !full && (state == ADDR || state == BYTE1 || state == BYTE2)) begin
                sh   <= {sh[6:0], sda_s};
                cnt  <= cnt + 3'd1;
                full <= cnt == 3'd7;
            end else if (scl_fall) begin
                // ACK states never count bits, so clearing on a full byte covers every state entry
                if (full) begin
                    cnt  <= '0;
                    full <= 1'b0;
                end
                case (state)
                    ADDR: if (full) begin
                        state    <= sh == {DEV_ADDR, 1'b0} ? ACK_A : IGNORE;
                        o_sda_oe <= sh == {DEV_ADDR, 1'b0};
                    end
                    ACK_A: begin
                        state    <= BYTE1;
                        o_sda_oe <= 1'b0;
                    end
                    BYTE1: if (full) begin
                        b1       <= sh;
                        state    <= ACK_1;
                        o_sda_oe <= 1'b1;
                    end
                    ACK_1: begin
                        state    <= BYTE2;
                        o_sda_oe <= 1'b0;
                    end
                    BYTE2: if (full) begin
                        state      <= ACK_2;
                        o_sda_oe   <= 1'b1;
                        o_wr_valid <= 1'b1;
                        o_wr_addr  <= waddr;
                        o_wr_data  <= wdata;
`ifdef CODEC_SOFT_RESET_EN
                        if (waddr == 7'h0F) begin
                            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
                        end else if (in_range) begin
                            regs[waddr[AW-1:0]] <= wdata;
                        end
`else
                        if (in_range) regs[waddr[AW-1:0]] <= wdata;
`endif
                    end
                    ACK_2: begin
                        state    <= IGNORE;
                        o_sda_oe <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_codec_responder.sv
// tb_i2c_codec_responder: directed I2C master driving the responder, checking ACKs, write pulses and register contents.
module tb_i2c_codec_responder;
    localparam int Q = 8;
    logic clk = 1'b0, rst = 1'b1, scl = 1'b1, m_sda = 1'b1;
    logic [3:0] rd_addr = '0;
    logic sda_bus, sda_oe, wr_valid, busy;
    logic [6:0] wr_addr;
    logic [8:0] wr_data, rd_data;
    logic [8:0] exp_regs [16];
    int checks = 0, passed = 0, wr_cnt = 0, oe_cnt = 0;
    int w0, o0, acks;
    logic k;

    assign sda_bus = m_sda & ~sda_oe;
    always #5 clk = ~clk;

    i2c_codec_responder dut (
        .i_clk(clk), .i_rst(rst), .i_scl(scl), .i_sda(sda_bus), .o_sda_oe(sda_oe),
        .o_wr_valid(wr_valid), .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_busy(busy),
        .i_rd_addr(rd_addr), .o_rd_data(rd_data)
    );

    always @(negedge clk) begin
        if (wr_valid) wr_cnt++;
        if (sda_oe) oe_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        tick(2); m_sda = 1'b1; tick(Q); scl = 1'b1; tick(Q); m_sda = 1'b0; tick(Q); scl = 1'b0;
    endtask

    task automatic i2c_stop;
        tick(2); m_sda = 1'b0; tick(Q); scl = 1'b1; tick(Q); m_sda = 1'b1; tick(Q);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            tick(2); m_sda = b[i]; tick(Q - 2); scl = 1'b1; tick(Q); scl = 1'b0;
        end
    endtask

    task automatic ack_clock(output logic ack);
        tick(2); m_sda = 1'b1; tick(Q - 2); scl = 1'b1; tick(Q / 2); ack = ~sda_bus; tick(Q / 2); scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b);
        ack_clock(ack);
    endtask

    task automatic write_word(input logic [6:0] a, input logic [8:0] d, output int n);
        logic ak;
        i2c_start;
        send_byte(8'h34, ak); n = int'(ak);
        send_byte({a, d[8]}, ak); n += int'(ak);
        send_byte(d[7:0], ak); n += int'(ak);
        i2c_stop;
    endtask

    task automatic model_write(input logic [6:0] a, input logic [8:0] d);
`ifdef CODEC_SOFT_RESET_EN
        if (a == 7'h0F) begin
            for (int i = 0; i < 16; i++) exp_regs[i] = '0;
        end else if (a < 7'd16) exp_regs[a[3:0]] = d;
`else
        if (a < 7'd16) exp_regs[a[3:0]] = d;
`endif
    endtask

    task automatic check_reg(input int a);
        rd_addr = 4'(a);
        #1;
        check($sformatf("reg%0d", a), 32'(rd_data), 32'(exp_regs[a]));
    endtask

    task automatic check_all;
        for (int i = 0; i < 16; i++) check_reg(i);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) exp_regs[i] = '0;
        tick(4); rst = 1'b0; tick(2);
        check("rst_oe", 32'(sda_oe), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check_all;

        // basic write: reg 4 <= 0x015
        w0 = wr_cnt;
        i2c_start;
        send_byte(8'h34, k); check("t1_ack_addr", 32'(k), 1);
        send_byte(8'h08, k); check("t1_ack_b1", 32'(k), 1);
        send_byte(8'h15, k); check("t1_ack_b2", 32'(k), 1);
        check("t1_busy", 32'(busy), 1);
        i2c_stop;
        check("t1_idle", 32'(busy), 0);
        check("t1_wr_cnt", 32'(wr_cnt - w0), 1);
        check("t1_wr_addr", 32'(wr_addr), 32'h04);
        check("t1_wr_data", 32'(wr_data), 32'h015);
        exp_regs[4] = 9'h015;
        check_reg(4);

        // wrong device address
        w0 = wr_cnt;
        i2c_start;
        send_byte(8'h36, k); check("t2_ack_addr", 32'(k), 0);
        send_byte(8'h08, k); check("t2_ack_b1", 32'(k), 0);
        send_byte(8'h15, k); check("t2_ack_b2", 32'(k), 0);
        i2c_stop;
        check("t2_wr_cnt", 32'(wr_cnt - w0), 0);
        check_reg(4);

        // read request is NACKed and never drives SDA
        w0 = wr_cnt; o0 = oe_cnt;
        i2c_start;
        send_byte(8'h35, k); check("t3_ack_addr", 32'(k), 0);
        send_byte(8'h08, k);
        i2c_stop;
        check("t3_oe_cycles", 32'(oe_cnt - o0), 0);
        check("t3_wr_cnt", 32'(wr_cnt - w0), 0);

        // partial word dropped by STOP, then repeated START mid-transfer
        w0 = wr_cnt;
        i2c_start;
        send_byte(8'h34, k); check("t4_ack_addr", 32'(k), 1);
        send_byte(8'h0E, k); check("t4_ack_b1", 32'(k), 1);
        i2c_stop;
        check("t4_wr_cnt_stop", 32'(wr_cnt - w0), 0);
        check_reg(7);
        i2c_start;
        send_byte(8'h34, k);
        send_byte(8'h01, k);
        i2c_start;
        send_byte(8'h34, k); check("t4_rs_ack_addr", 32'(k), 1);
        send_byte(8'h0E, k);
        send_byte(8'h42, k); check("t4_rs_ack_b2", 32'(k), 1);
        i2c_stop;
        check("t4_wr_cnt_rs", 32'(wr_cnt - w0), 1);
        exp_regs[7] = 9'h042;
        check_reg(7);
        check_reg(0);

        // fill regs 0..6, then write reg 0x0F
        for (int i = 0; i < 7; i++) begin
            write_word(7'(i), 9'(9'h0A0 + i), acks);
            model_write(7'(i), 9'(9'h0A0 + i));
        end
        check("t5_fill_acks", 32'(acks), 3);
        write_word(7'h0F, 9'h000, acks);
        model_write(7'h0F, 9'h000);
        check("t5_wr_addr", 32'(wr_addr), 32'h0F);
        check_all;

        // ninth data bit and out-of-range register
        write_word(7'h05, 9'h1FF, acks);
        model_write(7'h05, 9'h1FF);
        check("d8_wr_data", 32'(wr_data), 32'h1FF);
        check_reg(5);
        w0 = wr_cnt;
        write_word(7'h20, 9'h055, acks);
        check("oor_acks", 32'(acks), 3);
        check("oor_wr_cnt", 32'(wr_cnt - w0), 1);
        check("oor_wr_addr", 32'(wr_addr), 32'h20);
        check_all;

        // reset during ACK_1 drive
        w0 = wr_cnt;
        i2c_start;
        send_byte(8'h34, k);
        send_bits(8'h08);
        m_sda = 1'b1;
        for (int i = 0; i < 20 && !sda_oe; i++) tick(1);
        check("t6_ack1_drive", 32'(sda_oe), 1);
        rst = 1'b1;
        tick(1);
        check("t6_oe_released", 32'(sda_oe), 0);
        rst = 1'b0;
        ack_clock(k);
        send_byte(8'h15, k);
        i2c_stop;
        check("t6_wr_cnt", 32'(wr_cnt - w0), 0);
        for (int i = 0; i < 16; i++) exp_regs[i] = '0;
        check_reg(4);
        write_word(7'h04, 9'h015, acks);
        check("t6_after_acks", 32'(acks), 3);
        exp_regs[4] = 9'h015;
        check_reg(4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
